// File: rtl/snn_sched_pkg.sv
// -----------------------------------------------------------------------------
// snn_sched_pkg
// Shared definitions for the SNN time-step scheduler:
//   - sched_state_t      : scheduler FSM state encoding
//   - DEFAULT_TIME_WIDTH : default width of the sim-time / time-step counters
// -----------------------------------------------------------------------------
package snn_sched_pkg;

    localparam int DEFAULT_TIME_WIDTH = 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_NET_RST = 3'd1,
        ST_GEN     = 3'd2,
        ST_LAYER   = 3'd3,
        ST_WAIT    = 3'd4,
        ST_STEP    = 3'd5,
        ST_DONE    = 3'd6
    } sched_state_t;

endpackage

// File: rtl/snn_sched_timeout_cnt.sv
// -----------------------------------------------------------------------------
// snn_sched_timeout_cnt
// Layer watchdog: counts cycles while enable is high and flags expired during
// the TIMEOUT_CYCLES-th consecutive enabled cycle. clear has priority and
// restarts the count.
// Ports:
//   S_AXI_ACLK    in  clock (rising edge)
//   S_AXI_ARESETN in  asynchronous active-low reset
//   clear         in  restart the count
//   enable        in  count this cycle
//   expired       out limit reached in the current enabled cycle
// -----------------------------------------------------------------------------
module snn_sched_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic S_AXI_ACLK,
    input  logic S_AXI_ARESETN,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_q;

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && !expired) begin
            count_q <= count_q + CW'(1);
        end
    end

    // count_q holds the number of enabled cycles already elapsed, so the
    // limit is hit while count_q sits one below TIMEOUT_CYCLES.
    assign expired = enable && (count_q == LAST);

endmodule

// File: rtl/snn_timestep_scheduler.sv
// -----------------------------------------------------------------------------
// snn_timestep_scheduler
// Sequences a spiking-network run: one neuron-state reset, then for each time
// step a spike-generator strobe followed by a start/done handshake with every
// layer in order, until the requested number of time steps has completed.
//
// Optional feature: define SNN_SCHED_TIMEOUT_EN to add a per-layer watchdog
// (TIMEOUT_CYCLES) that aborts the run and raises the sticky error_o.
//
// Ports:
//   S_AXI_ACLK      in   clock (rising edge)
//   S_AXI_ARESETN   in   asynchronous active-low reset
//   start_i         in   one-cycle run request (honoured only in IDLE)
//   abort_i         in   cancel the current run
//   sim_time_i      in   number of time steps, latched at start
//   net_reset_o     out  one-cycle neuron-state reset pulse
//   spike_gen_en_o  out  one-cycle spike-generator advance strobe
//   layer_start_o   out  one-hot one-cycle layer start pulse
//   layer_done_i    in   per-layer completion pulses
//   timestep_o      out  completed time steps
//   busy_o          out  high outside IDLE
//   done_o          out  one-cycle run-complete pulse
//   error_o         out  sticky watchdog error (0 without the watchdog)
// -----------------------------------------------------------------------------
module snn_timestep_scheduler
    import snn_sched_pkg::*;
#(
    parameter int NUM_LAYERS     = 2,
    parameter int TIME_WIDTH     = DEFAULT_TIME_WIDTH,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  S_AXI_ACLK,
    input  logic                  S_AXI_ARESETN,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [TIME_WIDTH-1:0] sim_time_i,
    output logic                  net_reset_o,
    output logic                  spike_gen_en_o,
    output logic [NUM_LAYERS-1:0] layer_start_o,
    input  logic [NUM_LAYERS-1:0] layer_done_i,
    output logic [TIME_WIDTH-1:0] timestep_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o
);

    localparam int LW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam logic [LW-1:0] LAST_LAYER = LW'(NUM_LAYERS - 1);

    sched_state_t          state_q, state_d;
    logic [LW-1:0]         layer_q;
    logic [TIME_WIDTH-1:0] timestep_q;
    logic [TIME_WIDTH-1:0] sim_time_q;
    logic                  layer_done_sel;
    logic                  wd_expired;
    logic                  start_ok;
    logic                  aborting;

    // Only the bit of the layer currently being waited on is ever looked at.
    assign layer_done_sel = layer_done_i[layer_q];
    assign start_ok       = (state_q == ST_IDLE) && start_i;
    assign aborting       = abort_i && (state_q != ST_IDLE);

    // Next-state logic; abort overrides everything, including a same-cycle done.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (start_i) state_d = ST_NET_RST;
            ST_NET_RST: state_d = (sim_time_q == '0) ? ST_DONE : ST_GEN;
            ST_GEN:     state_d = ST_LAYER;
            ST_LAYER:   state_d = ST_WAIT;
            ST_WAIT: begin
                if (layer_done_sel) begin
                    state_d = (layer_q == LAST_LAYER) ? ST_STEP : ST_LAYER;
                end else if (wd_expired) begin
                    state_d = ST_IDLE;
                end
            end
            ST_STEP: begin
                state_d = ((timestep_q + TIME_WIDTH'(1)) == sim_time_q) ? ST_DONE : ST_GEN;
            end
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
        if (aborting) state_d = ST_IDLE;
    end

    // Control registers
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_q    <= ST_IDLE;
            layer_q    <= '0;
            timestep_q <= '0;
        end else begin
            state_q <= state_d;
            if (start_ok) begin
                timestep_q <= '0;
            end else if (state_q == ST_STEP && !aborting) begin
                timestep_q <= timestep_q + TIME_WIDTH'(1);
            end
            if (state_q == ST_GEN) begin
                layer_q <= '0;
            end else if (state_q == ST_WAIT && layer_done_sel && !aborting &&
                         layer_q != LAST_LAYER) begin
                layer_q <= layer_q + LW'(1);
            end
        end
    end

    // Run length is data captured once per start; it needs no reset.
    always_ff @(posedge S_AXI_ACLK) begin
        if (start_ok) sim_time_q <= sim_time_i;
    end

`ifdef SNN_SCHED_TIMEOUT_EN
    logic error_q;

    snn_sched_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .S_AXI_ACLK   (S_AXI_ACLK),
        .S_AXI_ARESETN(S_AXI_ARESETN),
        .clear        (state_q != ST_WAIT),
        .enable       (state_q == ST_WAIT),
        .expired      (wd_expired)
    );

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            error_q <= 1'b0;
        end else if (start_ok) begin
            error_q <= 1'b0;
        end else if (state_q == ST_WAIT && wd_expired && !layer_done_sel && !aborting) begin
            error_q <= 1'b1;
        end
    end

    assign error_o = error_q;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign wd_expired         = 1'b0;
    assign error_o            = 1'b0;
`endif

    // Outputs decode directly from the state register, so reset clears them at once.
    assign net_reset_o    = (state_q == ST_NET_RST);
    assign spike_gen_en_o = (state_q == ST_GEN);
    assign layer_start_o  = (state_q == ST_LAYER) ? (NUM_LAYERS'(1) << layer_q) : '0;
    assign done_o         = (state_q == ST_DONE);
    assign busy_o         = (state_q != ST_IDLE);
    assign timestep_o     = timestep_q;

endmodule
